// File: rtl/serial_slave_regfile.sv
// serial_slave_regfile: framed one-bit-per-clock serial slave with a small register bank.
// Frame (MSB first): start(0), address, R/W (1=read), ACK slot, index, data.
// Writes land in reg[idx]. Reads shift reg[idx] out on TX.
// Ports:
//   CLK, RST    - clock and synchronous active-high reset
//   RX, TX      - serial in and registered serial out; both idle high
//   BUSY        - high while a frame is in progress
//   DONE, ERR   - one-cycle pulses at the end of a matched frame; ERR marks an index >= NREGS
//   HOST_IDX, HOST_RDATA - combinational host-side register peek
module serial_slave_regfile #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] DEV_ADDR = 8'h4D,
  parameter int                DATA_W   = 8,
  parameter int                NREGS    = 4,
  parameter int                IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  input  logic [IDX_W-1:0]  HOST_IDX,
  output logic [DATA_W-1:0] HOST_RDATA
);

  // Wide enough for the longest field count and for the skip length.
  localparam int CNT_W = $clog2(ADDR_W + IDX_W + DATA_W + 2);
  localparam logic [CNT_W-1:0] SKIP_LEN = CNT_W'(1 + IDX_W + DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RW,
    ACK,
    IDX,
    WDATA,
    RDATA,
    SKIP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                rw_q, rw_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wr_en;

  logic [DATA_W-1:0]   regs [NREGS];

  // Index value including the bit sampled on this edge; used on the last index edge.
  logic [IDX_W-1:0]    idx_shift;
  logic [DATA_W-1:0]   rd_word;
  logic                idx_ok;

  assign idx_shift = IDX_W'({idx_q, RX});
  assign idx_ok    = (int'(idx_q) < NREGS);

  // Register selected by the completed index; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_shift == IDX_W'(i)) rd_word = regs[i];
    end
  end

  always_comb begin
    HOST_RDATA = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (HOST_IDX == IDX_W'(i)) HOST_RDATA = regs[i];
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!RX) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end

      ADDR: begin
        addr_d = ADDR_W'({addr_q, RX});
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          state_d = RW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RW: begin
        if (addr_q == DEV_ADDR) begin
          rw_d    = RX;
          tx_d    = 1'b0;   // acknowledge during the following cycle
          state_d = ACK;
        end else begin
          // Stay silent for the rest of the frame so frame length never depends on match.
          state_d = SKIP;
          cnt_d   = SKIP_LEN;
        end
      end

      ACK: begin
        tx_d    = 1'b1;
        state_d = IDX;
        cnt_d   = '0;
      end

      IDX: begin
        idx_d = idx_shift;
        if (cnt_q == CNT_W'(IDX_W - 1)) begin
          cnt_d = '0;
          if (rw_q) begin
            shift_d = rd_word;
            tx_d    = rd_word[DATA_W-1];
            state_d = RDATA;
          end else begin
            state_d = WDATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RDATA: begin
        // cnt_q counts bits already presented; the edge after the LSB cycle ends the frame.
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          err_d   = !idx_ok;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shift_d = shift_q << 1;
          tx_d    = shift_d[DATA_W-1];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      WDATA: begin
        shift_d = DATA_W'({shift_q, RX});
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          wr_en   = idx_ok;
          done_d  = 1'b1;
          err_d   = !idx_ok;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SKIP: begin
        tx_d  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rw_q    <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en && idx_q == IDX_W'(i)) regs[i] <= shift_d;
      end
    end
  end

  assign TX   = tx_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_serial_slave_regfile.sv
// Bench for serial_slave_regfile: two instances (NREGS=4 and NREGS=3) share one RX stream.
// A frame-level model derives per-cycle TX/BUSY/DONE/ERR/HOST_RDATA for each instance.
// Directed frames from the test plan come first, then randomized frames with random aborts.
module tb_serial_slave_regfile;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;
  localparam logic [7:0] DEV = 8'h4D;
  localparam int L = ADDR_W + IDX_W + 2;          // edge sampling the last index bit
  localparam int F = ADDR_W + IDX_W + DATA_W + 2; // last edge of a frame

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [1:0] host_idx;
  logic [1:0] tx, busy, done, err;
  logic [7:0] hrd [2];

  int         vecs = 0;
  int         errs = 0;
  logic       chk = 1'b0;

  // Model state.
  int         nregs [2] = '{4, 3};
  logic [7:0] mreg [2][4];
  logic       exp_tx [2], exp_busy [2], exp_done [2], exp_err [2];
  logic [7:0] rd_mdl [2];  // model TX bits of the last read
  logic [7:0] rd_dut [2];  // DUT TX bits of the last read

  always #5 clk = ~clk;

  serial_slave_regfile dut_a (
    .CLK(clk), .RST(rst), .RX(rx), .TX(tx[0]), .BUSY(busy[0]), .DONE(done[0]),
    .ERR(err[0]), .HOST_IDX(host_idx), .HOST_RDATA(hrd[0])
  );

  serial_slave_regfile #(.NREGS(3)) dut_b (
    .CLK(clk), .RST(rst), .RX(rx), .TX(tx[1]), .BUSY(busy[1]), .DONE(done[1]),
    .ERR(err[1]), .HOST_IDX(host_idx), .HOST_RDATA(hrd[1])
  );

  task automatic cmp(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, u, $time, act, exp);
    end
  endtask

  // Compare process: every cycle once checking is enabled.
  always @(negedge clk) begin
    if (chk) begin
      for (int u = 0; u < 2; u++) begin
        logic [7:0] eh;
        eh = (int'(host_idx) < nregs[u]) ? mreg[u][host_idx] : 8'h00;
        cmp("TX",         u, 32'(tx[u]),   32'(exp_tx[u]));
        cmp("BUSY",       u, 32'(busy[u]), 32'(exp_busy[u]));
        cmp("DONE",       u, 32'(done[u]), 32'(exp_done[u]));
        cmp("ERR",        u, 32'(err[u]),  32'(exp_err[u]));
        cmp("HOST_RDATA", u, 32'(hrd[u]),  32'(eh));
      end
    end
  end

  task automatic drive(input logic r, input logic x);
    rst      = r;
    rx       = x;
    host_idx = 2'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    for (int u = 0; u < 2; u++) begin
      exp_tx[u] = 1'b1; exp_busy[u] = 1'b0; exp_done[u] = 1'b0; exp_err[u] = 1'b0;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1);
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) mreg[u][i] = 8'h00;
    set_idle_exp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1);
      set_idle_exp();
    end
  endtask

  // One frame; abort_at >= 0 asserts reset on that edge instead of the frame bit.
  task automatic frame(input logic [7:0] a, input logic rd, input logic [1:0] ix,
                       input logic [7:0] d, input int abort_at);
    logic [F:0] bits;
    logic [7:0] snap [2];
    logic       match;
    bits  = {1'b0, a, rd, 1'b1, ix, d};
    match = (a == DEV);
    for (int u = 0; u < 2; u++) begin
      snap[u]   = (int'(ix) < nregs[u]) ? mreg[u][ix] : 8'h00;
      rd_mdl[u] = 8'h00;
      rd_dut[u] = 8'h00;
    end
    for (int j = 0; j <= F; j++) begin
      logic b;
      b = bits[F-j];
      // RX is meaningless in the ACK slot and while read data goes out.
      if (j == ADDR_W + 2 || (rd && j > L)) b = 1'($urandom);
      if (j == abort_at) begin
        do_reset();
        return;
      end
      drive(1'b0, b);
      for (int u = 0; u < 2; u++) begin
        exp_busy[u] = (j < F);
        exp_tx[u]   = 1'b1;
        if (match && j == ADDR_W + 1) exp_tx[u] = 1'b0;
        if (match && rd && j >= L && j < F) begin
          exp_tx[u] = snap[u][DATA_W-1-(j-L)];
          rd_mdl[u][DATA_W-1-(j-L)] = exp_tx[u];
          rd_dut[u][DATA_W-1-(j-L)] = tx[u];
        end
        exp_done[u] = match && (j == F);
        exp_err[u]  = match && (j == F) && (int'(ix) >= nregs[u]);
        if (match && !rd && j == F && int'(ix) < nregs[u]) mreg[u][ix] = d;
      end
    end
  endtask

  task automatic peek(input string nm, input int u, input logic [1:0] ix, input logic [7:0] exp);
    host_idx = ix;
    #1;
    cmp(nm, u, 32'(hrd[u]), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    host_idx = 2'd0;
    set_idle_exp();

    // Reset state.
    do_reset();
    chk = 1'b1;
    do_reset();
    idle(2);

    // Write 0x5D to idx 2.
    frame(DEV, 1'b0, 2'd2, 8'h5D, -1);
    idle(1);
    cmp("model_reg2_5D", 0, 32'(mreg[0][2]), 32'h5D);
    peek("host_idx2", 0, 2'd2, 8'h5D);
    peek("host_idx1", 0, 2'd1, 8'h00);

    // Read back idx 2: 0,1,0,1,1,1,0,1.
    frame(DEV, 1'b1, 2'd2, 8'h00, -1);
    idle(1);
    cmp("model_rd_5D", 0, 32'(rd_mdl[0]), 32'h5D);
    cmp("dut_rd_5D",   0, 32'(rd_dut[0]), 32'h5D);

    // Address mismatch: write idx 1 with 0xFF must be ignored.
    frame(8'h4C, 1'b0, 2'd1, 8'hFF, -1);
    idle(1);
    peek("mismatch_reg1", 0, 2'd1, 8'h00);

    // Reset during data bit 4 of a write, then a full write of 0xA5 to idx 0.
    frame(DEV, 1'b0, 2'd1, 8'hC3, L + 5);
    peek("abort_reg2_cleared", 0, 2'd2, 8'h00);
    peek("abort_reg1", 0, 2'd1, 8'h00);
    frame(DEV, 1'b0, 2'd0, 8'hA5, -1);
    idle(1);
    peek("after_abort_reg0", 0, 2'd0, 8'hA5);

    // Back-to-back write then read of idx 3, no gap.
    frame(DEV, 1'b0, 2'd3, 8'h3C, -1);
    frame(DEV, 1'b1, 2'd3, 8'h00, -1);
    idle(1);
    cmp("b2b_rd_3C", 0, 32'(rd_dut[0]), 32'h3C);
    cmp("oor_rd_00", 1, 32'(rd_dut[1]), 32'h00);

    // Out-of-range on the NREGS=3 instance: write 0x77 to idx 3.
    frame(DEV, 1'b0, 2'd3, 8'h77, -1);
    idle(1);
    peek("oor_host3", 1, 2'd3, 8'h00);
    peek("oor_reg0_kept", 1, 2'd0, 8'hA5);

    // Randomized frames.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      int ab;
      a  = ($urandom_range(1, 0) == 1) ? DEV : 8'($urandom);
      ab = ($urandom_range(9, 0) == 0) ? int'($urandom_range(F, 1)) : -1;
      frame(a, 1'($urandom), 2'($urandom), 8'($urandom), ab);
      idle(int'($urandom_range(2, 0)));
    end

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
